// File: rtl/itch_msg_assembler_if.sv
// Handshake bundle between the MoldUDP64 parser, the message assembler and the ITCH decoder.
// The assembler sits on the slave side; the master modport is the parser/decoder environment.
interface itch_msg_assembler_if #(
  parameter int AXI_DATA_W    = 64,
  parameter int AXI_KEEP_W    = AXI_DATA_W/8,
  parameter int ML_W          = 16,
  parameter int SID_W         = 80,
  parameter int SEQ_NUM_W     = 64,
  parameter int MSG_MAX_BYTES = 64
);
  logic                       mold_msg_v_i;
  logic                       mold_msg_start_i;
  logic [ML_W-1:0]            mold_msg_len_i;
  logic [SEQ_NUM_W-1:0]       mold_msg_seq_num_i;
  logic [SID_W-1:0]           mold_msg_sid_i;
  logic [AXI_KEEP_W-1:0]      mold_msg_mask_i;
  logic [AXI_DATA_W-1:0]      mold_msg_data_i;
  logic                       itch_msg_v_o;
  logic                       itch_msg_ready_i;
  logic [ML_W-1:0]            itch_msg_len_o;
  logic [SEQ_NUM_W-1:0]       itch_msg_seq_num_o;
  logic [SID_W-1:0]           itch_msg_sid_o;
  logic [8*MSG_MAX_BYTES-1:0] itch_msg_data_o;
  logic                       itch_msg_drop_o;
  logic                       itch_msg_err_o;

  modport master (
    output mold_msg_v_i, mold_msg_start_i, mold_msg_len_i, mold_msg_seq_num_i,
           mold_msg_sid_i, mold_msg_mask_i, mold_msg_data_i, itch_msg_ready_i,
    input  itch_msg_v_o, itch_msg_len_o, itch_msg_seq_num_o, itch_msg_sid_o,
           itch_msg_data_o, itch_msg_drop_o, itch_msg_err_o
  );

  modport slave (
    input  mold_msg_v_i, mold_msg_start_i, mold_msg_len_i, mold_msg_seq_num_i,
           mold_msg_sid_i, mold_msg_mask_i, mold_msg_data_i, itch_msg_ready_i,
    output itch_msg_v_o, itch_msg_len_o, itch_msg_seq_num_o, itch_msg_sid_o,
           itch_msg_data_o, itch_msg_drop_o, itch_msg_err_o
  );
endinterface

// File: rtl/itch_msg_assembler.sv
// Rebuilds parser data beats into one wide LSB-first message and offers it over valid/ready.
// No backpressure upstream: a completion that finds the output busy is dropped and flagged.
module itch_msg_assembler #(
  parameter int AXI_DATA_W    = 64,
  parameter int AXI_KEEP_W    = AXI_DATA_W/8,
  parameter int ML_W          = 16,
  parameter int SID_W         = 80,
  parameter int SEQ_NUM_W     = 64,
  parameter int MSG_MAX_BYTES = 64
) (
  input logic                 clk,
  input logic                 nreset,
  itch_msg_assembler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ASSEMBLE, DISCARD} state_t;

  state_t                     state_q, state_d;
  logic [ML_W-1:0]            cnt_q, cnt_d, len_q, len_d;
  logic [SEQ_NUM_W-1:0]       seq_q, seq_d, out_seq_q, out_seq_d;
  logic [SID_W-1:0]           sid_q, sid_d, out_sid_q, out_sid_d;
  logic [8*MSG_MAX_BYTES-1:0] buf_q, buf_d, out_data_q, out_data_d;
  logic [ML_W-1:0]            out_len_q, out_len_d;
  logic                       v_q, v_d, err_q, err_d, drop_q, drop_d;

  logic [AXI_DATA_W-1:0]      beat_data;
  logic [ML_W-1:0]            pop, base, eff_len;
  logic [ML_W:0]              fill;
  logic                       beat_v, start_v, bad_len, complete, load, wr_en;
  int unsigned                pop_n, base_n, len_n;

  function automatic logic [ML_W-1:0] lane_count(input logic [AXI_KEEP_W-1:0] m);
    logic [ML_W-1:0] c;
    c = '0;
    for (int j = 0; j < AXI_KEEP_W; j++) c = c + ML_W'(m[j]);
    return c;
  endfunction

  assign beat_data = bus.mold_msg_data_i;
  assign beat_v    = bus.mold_msg_v_i;
  assign start_v   = beat_v & bus.mold_msg_start_i;
  assign pop       = lane_count(bus.mold_msg_mask_i);
  assign bad_len   = (bus.mold_msg_len_i == '0) ||
                     (32'(bus.mold_msg_len_i) > 32'(MSG_MAX_BYTES));
  // A start beat always writes at offset 0 against its own length.
  assign base      = start_v ? '0 : cnt_q;
  assign eff_len   = start_v ? bus.mold_msg_len_i : len_q;
  assign fill      = {1'b0, base} + {1'b0, pop};
  assign pop_n     = 32'(pop);
  assign base_n    = 32'(base);
  assign len_n     = 32'(eff_len);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      seq_q      <= '0;
      sid_q      <= '0;
      buf_q      <= '0;
      out_len_q  <= '0;
      out_seq_q  <= '0;
      out_sid_q  <= '0;
      out_data_q <= '0;
      v_q        <= 1'b0;
      err_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      seq_q      <= seq_d;
      sid_q      <= sid_d;
      buf_q      <= buf_d;
      out_len_q  <= out_len_d;
      out_seq_q  <= out_seq_d;
      out_sid_q  <= out_sid_d;
      out_data_q <= out_data_d;
      v_q        <= v_d;
      err_q      <= err_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start_v) begin
      if (bad_len)                        state_d = DISCARD;
      else if (fill >= {1'b0, eff_len})   state_d = IDLE;
      else                                state_d = ASSEMBLE;
    end else if (beat_v && state_q == ASSEMBLE && fill >= {1'b0, eff_len}) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    len_d    = len_q;
    seq_d    = seq_q;
    sid_d    = sid_q;
    buf_d    = buf_q;
    err_d    = 1'b0;
    wr_en    = 1'b0;
    complete = 1'b0;
    if (start_v) begin
      err_d = (state_q == ASSEMBLE) || bad_len;
      len_d = bus.mold_msg_len_i;
      seq_d = bus.mold_msg_seq_num_i;
      sid_d = bus.mold_msg_sid_i;
      buf_d = '0;
      cnt_d = '0;
      if (!bad_len) begin
        wr_en    = 1'b1;
        cnt_d    = pop;
        complete = fill >= {1'b0, eff_len};
      end
    end else if (beat_v) begin
      if (state_q == ASSEMBLE) begin
        wr_en    = 1'b1;
        cnt_d    = fill[ML_W-1:0];
        complete = fill >= {1'b0, eff_len};
      end else if (state_q == IDLE) begin
        err_d = 1'b1;
      end
    end
    // Lanes past the message length are never written, so tail bytes stay zero.
    if (wr_en) begin
      for (int unsigned i = 0; i < MSG_MAX_BYTES; i++) begin
        for (int unsigned j = 0; j < AXI_KEEP_W; j++) begin
          if (j < pop_n && base_n + j == i && i < len_n) buf_d[8*i +: 8] = beat_data[8*j +: 8];
        end
      end
    end

    load       = complete && (!v_q || bus.itch_msg_ready_i);
    drop_d     = complete && !load;
    out_len_d  = load ? len_d : out_len_q;
    out_seq_d  = load ? seq_d : out_seq_q;
    out_sid_d  = load ? sid_d : out_sid_q;
    out_data_d = load ? buf_d : out_data_q;
    v_d        = load ? 1'b1 : (v_q && !bus.itch_msg_ready_i);
  end

  assign bus.itch_msg_v_o       = v_q;
  assign bus.itch_msg_len_o     = out_len_q;
  assign bus.itch_msg_seq_num_o = out_seq_q;
  assign bus.itch_msg_sid_o     = out_sid_q;
  assign bus.itch_msg_data_o    = out_data_q;
  assign bus.itch_msg_drop_o    = drop_q;
  assign bus.itch_msg_err_o     = err_q;
endmodule
